// File: rtl/debug_sequencer_if.sv
// Signal bundle between the debug sequencer and its UART and pipeline.
// The master modport is the sequencer side; the slave modport is the environment side.
interface debug_sequencer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        halt;
  logic [31:0] in_pc;
  logic [31:0] in_fr_data;
  logic [31:0] in_mem_data;
  logic [31:0] in_latch;
  logic        pipe_en;
  logic        soft_rst;
  logic        debug_on;
  logic [31:0] debug_addr;
  logic [6:0]  latch_sel;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  led;

  modport master (
    input  rx_valid, rx_data, tx_busy, halt, in_pc, in_fr_data, in_mem_data, in_latch,
    output pipe_en, soft_rst, debug_on, debug_addr, latch_sel, tx_start, tx_data, led
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, halt, in_pc, in_fr_data, in_mem_data, in_latch,
    input  pipe_en, soft_rst, debug_on, debug_addr, latch_sel, tx_start, tx_data, led
  );
endinterface

// File: rtl/debug_sequencer.sv
// UART-driven debug sequencer: run/step/soft-reset control of a pipeline and a
// byte-serial dump of PC, register file, pipeline latches and data memory.
module debug_sequencer #(
  parameter int MEM_WORDS   = 32,
  parameter int LATCH_WORDS = 16
) (
  input logic               clk,
  input logic               rst,
  debug_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SRST   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_D_ADDR = 3'd4,
    S_D_WAIT = 3'd5,
    S_D_SEND = 3'd6,
    S_D_BUSY = 3'd7
  } state_t;

  // Word index layout: 0 = PC, then 32 registers, then latches, then memory.
  localparam logic [8:0] REG_BASE   = 9'd1;
  localparam logic [8:0] LATCH_BASE = 9'd33;
  localparam logic [8:0] MEM_BASE   = 9'(33 + LATCH_WORDS);
  localparam logic [8:0] LAST_WORD  = 9'(32 + LATCH_WORDS + MEM_WORDS);

  state_t      state_r, next_state_s;
  logic [8:0]  widx_r, widx_next_s;
  logic [1:0]  byte_cnt_r, byte_next_s;
  logic        busy_seen_r, busy_seen_next_s;
  logic [31:0] shift_r, shift_next_s;
  logic        armed_r;
  logic        pipe_en_r, soft_rst_r, debug_on_r, tx_start_r;
  logic        tx_start_next_s, dump_next_s, cmd_s;
  logic [31:0] debug_addr_r, addr_next_s, word_s;
  logic [6:0]  latch_sel_r, sel_next_s, latch_num_s;
  logic [7:0]  tx_data_r, tx_data_next_s;
  logic [2:0]  led_r, led_next_s;
  logic [4:0]  reg_num_s;
  logic [8:0]  mem_num_s;

  assign bus.pipe_en    = pipe_en_r;
  assign bus.soft_rst   = soft_rst_r;
  assign bus.debug_on   = debug_on_r;
  assign bus.debug_addr = debug_addr_r;
  assign bus.latch_sel  = latch_sel_r;
  assign bus.tx_start   = tx_start_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.led        = led_r;

  // Commands are ignored in the first cycle after reset release.
  assign cmd_s = armed_r && bus.rx_valid;

  // Select the word being captured for the current dump index.
  always_comb begin
    word_s = bus.in_mem_data;
    if (widx_r == 9'd0) begin
      word_s = bus.in_pc;
    end else if (widx_r < LATCH_BASE) begin
      word_s = bus.in_fr_data;
    end else if (widx_r < MEM_BASE) begin
      word_s = bus.in_latch;
    end else begin
      word_s = bus.in_mem_data;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    next_state_s     = state_r;
    widx_next_s      = widx_r;
    byte_next_s      = byte_cnt_r;
    busy_seen_next_s = busy_seen_r;
    shift_next_s     = shift_r;
    tx_start_next_s  = 1'b0;
    tx_data_next_s   = tx_data_r;
    case (state_r)
      S_IDLE: begin
        widx_next_s = 9'd0;
        byte_next_s = 2'd0;
        if (cmd_s) begin
          case (bus.rx_data)
            8'h01:   next_state_s = S_RUN;
            8'h02: begin
              if (bus.halt) begin
                next_state_s = S_D_ADDR;
              end else begin
                next_state_s = S_STEP;
              end
            end
            8'h03:   next_state_s = S_D_ADDR;
            8'h04:   next_state_s = S_SRST;
            default: next_state_s = S_IDLE;
          endcase
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_SRST: begin
        if (byte_cnt_r == 2'd1) begin
          next_state_s = S_IDLE;
          byte_next_s  = 2'd0;
        end else begin
          byte_next_s = byte_cnt_r + 2'd1;
        end
      end
      S_RUN: begin
        widx_next_s = 9'd0;
        byte_next_s = 2'd0;
        if (bus.halt || (bus.rx_valid && (bus.rx_data == 8'h05))) begin
          next_state_s = S_D_ADDR;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_STEP: begin
        widx_next_s  = 9'd0;
        byte_next_s  = 2'd0;
        next_state_s = S_D_ADDR;
      end
      S_D_ADDR: next_state_s = S_D_WAIT;
      S_D_WAIT: begin
        shift_next_s = word_s;
        byte_next_s  = 2'd0;
        next_state_s = S_D_SEND;
      end
      S_D_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_next_s  = 1'b1;
          tx_data_next_s   = shift_r[7:0];
          busy_seen_next_s = 1'b0;
          next_state_s     = S_D_BUSY;
        end else begin
          next_state_s = S_D_SEND;
        end
      end
      S_D_BUSY: begin
        if (!busy_seen_r) begin
          busy_seen_next_s = bus.tx_busy;
        end else if (!bus.tx_busy) begin
          shift_next_s = {8'd0, shift_r[31:8]};
          if (byte_cnt_r == 2'd3) begin
            byte_next_s = 2'd0;
            if (widx_r == LAST_WORD) begin
              widx_next_s  = 9'd0;
              next_state_s = S_IDLE;
            end else begin
              widx_next_s  = widx_r + 9'd1;
              next_state_s = S_D_ADDR;
            end
          end else begin
            byte_next_s  = byte_cnt_r + 2'd1;
            next_state_s = S_D_SEND;
          end
        end else begin
          next_state_s = S_D_BUSY;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    dump_next_s = (next_state_s == S_D_ADDR) || (next_state_s == S_D_WAIT) ||
                  (next_state_s == S_D_SEND) || (next_state_s == S_D_BUSY);
    reg_num_s   = 5'(widx_next_s - REG_BASE);
    latch_num_s = 7'(widx_next_s - LATCH_BASE);
    mem_num_s   = widx_next_s - MEM_BASE;
    addr_next_s = 32'd0;
    sel_next_s  = 7'd0;
    if (dump_next_s) begin
      if ((widx_next_s >= REG_BASE) && (widx_next_s < LATCH_BASE)) begin
        addr_next_s = {27'd0, reg_num_s};
      end else if (widx_next_s >= MEM_BASE) begin
        addr_next_s = {23'd0, mem_num_s};
      end else begin
        addr_next_s = 32'd0;
      end
      if ((widx_next_s >= LATCH_BASE) && (widx_next_s < MEM_BASE)) begin
        sel_next_s = latch_num_s;
      end else begin
        sel_next_s = 7'd0;
      end
    end else begin
      addr_next_s = 32'd0;
      sel_next_s  = 7'd0;
    end
    case (next_state_s)
      S_IDLE:                                led_next_s = 3'b001;
      S_RUN, S_STEP:                         led_next_s = 3'b010;
      S_D_ADDR, S_D_WAIT, S_D_SEND, S_D_BUSY: led_next_s = 3'b100;
      default:                               led_next_s = 3'b000;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      widx_r       <= 9'd0;
      byte_cnt_r   <= 2'd0;
      busy_seen_r  <= 1'b0;
      shift_r      <= 32'd0;
      armed_r      <= 1'b0;
      pipe_en_r    <= 1'b0;
      soft_rst_r   <= 1'b0;
      debug_on_r   <= 1'b0;
      debug_addr_r <= 32'd0;
      latch_sel_r  <= 7'd0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'd0;
      led_r        <= 3'b001;
    end else begin
      state_r      <= next_state_s;
      widx_r       <= widx_next_s;
      byte_cnt_r   <= byte_next_s;
      busy_seen_r  <= busy_seen_next_s;
      shift_r      <= shift_next_s;
      armed_r      <= 1'b1;
      pipe_en_r    <= (next_state_s == S_RUN) || (next_state_s == S_STEP);
      soft_rst_r   <= (next_state_s == S_SRST);
      debug_on_r   <= dump_next_s;
      debug_addr_r <= addr_next_s;
      latch_sel_r  <= sel_next_s;
      tx_start_r   <= tx_start_next_s;
      tx_data_r    <= tx_data_next_s;
      led_r        <= led_next_s;
    end
  end
endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer: a behavioural UART transmitter and
// registered read ports record the dump stream and compare it against a model.
module tb_debug_sequencer;
  localparam logic [31:0] PC_VAL = 32'h0040_1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_sequencer_if dif ();

  debug_sequencer #(.MEM_WORDS(32), .LATCH_WORDS(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (dif)
  );

  logic [31:0] regs [32];
  logic [31:0] latches [16];
  logic [31:0] mem [32];
  logic [7:0]  stream [$];
  int          busy_len = 2;
  int          bcnt;
  logic        ext_busy = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          srst_cnt = 0;
  int          pe_cnt = 0;
  int          viol = 0;

  // Read ports with one cycle of latency after the address changes.
  always @(posedge clk) begin
    dif.in_fr_data  <= regs[dif.debug_addr[4:0]];
    dif.in_mem_data <= mem[dif.debug_addr[4:0]];
    dif.in_latch    <= latches[dif.latch_sel[3:0]];
  end

  // UART transmitter: busy from the cycle after tx_start for busy_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 0;
    end else if (dif.tx_start) begin
      stream.push_back(dif.tx_data);
      bcnt <= busy_len;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end
  assign dif.tx_busy = (bcnt != 0) || ext_busy;

  always @(negedge clk) begin
    if (dif.soft_rst) srst_cnt++;
    if (dif.pipe_en) pe_cnt++;
    if (dif.tx_start && dif.tx_busy) viol++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dif.rx_valid = 1'b1;
    dif.rx_data  = b;
    @(negedge clk);
    dif.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(dif.led == 3'b001 && !dif.debug_on) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, 32'(dif.led), 32'h1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0]  exp_q [$];
    logic [31:0] w;
    int bad = 0;
    for (int i = 0; i < 81; i++) begin
      if (i == 0) w = PC_VAL;
      else if (i < 33) w = regs[i - 1];
      else if (i < 49) w = latches[i - 33];
      else w = mem[i - 49];
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
    check_val({tag, "_len"}, 32'(stream.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= stream.size()) bad++;
      else if (stream[i] !== exp_q[i]) bad++;
    end
    check_val({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    if (stream.size() >= 28) begin
      check_val({tag, "_pc_word"}, {stream[3], stream[2], stream[1], stream[0]}, PC_VAL);
      check_val({tag, "_reg5"}, {stream[27], stream[26], stream[25], stream[24]}, 32'hDEAD_BEEF);
    end else begin
      check_val({tag, "_short"}, 32'(stream.size()), 32'd28);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pipe_en"}, 32'(dif.pipe_en), 32'd0);
    check_val({tag, "_soft_rst"}, 32'(dif.soft_rst), 32'd0);
    check_val({tag, "_debug_on"}, 32'(dif.debug_on), 32'd0);
    check_val({tag, "_debug_addr"}, dif.debug_addr, 32'd0);
    check_val({tag, "_latch_sel"}, 32'(dif.latch_sel), 32'd0);
    check_val({tag, "_tx_start"}, 32'(dif.tx_start), 32'd0);
    check_val({tag, "_tx_data"}, 32'(dif.tx_data), 32'd0);
    check_val({tag, "_led"}, 32'(dif.led), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      mem[i]  = 32'h5500_0000 + 32'(i) * 32'h0003_0507;
    end
    for (int i = 0; i < 16; i++) latches[i] = 32'hA000_0000 | (32'(i) << 8) | 32'(i + 64);
    regs[5] = 32'hDEAD_BEEF;
    dif.rx_valid = 1'b0;
    dif.rx_data  = 8'h00;
    dif.halt     = 1'b0;
    dif.in_pc    = PC_VAL;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // A command presented in the first cycle after release must be ignored.
    rst_n = 1'b1;
    dif.rx_valid = 1'b1;
    dif.rx_data  = 8'h04;
    @(negedge clk);
    dif.rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val("first_cycle_ignored", 32'(srst_cnt), 32'd0);

    // Soft reset.
    send(8'h04);
    repeat (6) @(negedge clk);
    check_val("srst_cycles", 32'(srst_cnt), 32'd2);
    check_val("srst_no_pipe_en", 32'(pe_cnt), 32'd0);
    check_val("srst_led_after", 32'(dif.led), 32'h1);

    // Single step with halt low, then a full dump.
    stream.delete();
    pe_cnt = 0;
    send(8'h02);
    wait_idle("step", 5000);
    check_val("step_pe_cycles", 32'(pe_cnt), 32'd1);
    check_stream("step");

    // Run, halt after 10 enabled cycles, command sent mid-dump is ignored.
    stream.delete();
    pe_cnt = 0;
    send(8'h01);
    repeat (9) @(negedge clk);
    check_val("run_led", 32'(dif.led), 32'h2);
    check_val("run_debug_on", 32'(dif.debug_on), 32'd0);
    dif.halt = 1'b1;
    @(negedge clk);
    check_val("run_pipe_en_drop", 32'(dif.pipe_en), 32'd0);
    repeat (50) @(negedge clk);
    check_val("dump_debug_on", 32'(dif.debug_on), 32'd1);
    send(8'h02);
    wait_idle("run", 5000);
    check_val("run_pe_cycles", 32'(pe_cnt), 32'd10);
    check_stream("run");
    repeat (10) @(negedge clk);
    check_val("ignored_step_led", 32'(dif.led), 32'h1);

    // Step with halt already high and a slow transmitter.
    stream.delete();
    pe_cnt = 0;
    busy_len = 50;
    send(8'h02);
    wait_idle("slow", 30000);
    check_val("halted_step_pe", 32'(pe_cnt), 32'd0);
    check_stream("slow");
    dif.halt = 1'b0;
    busy_len = 2;

    // Reset in the middle of a dump, then restart with the transmitter initially busy.
    stream.delete();
    send(8'h03);
    for (int n = 0; n < 5000 && stream.size() < 100; n++) @(negedge clk);
    check_val("reached_byte_100", 32'(stream.size() >= 100), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stream.delete();
    ext_busy = 1'b1;
    send(8'h03);
    repeat (30) @(negedge clk);
    check_val("stall_no_tx", 32'(stream.size()), 32'd0);
    check_val("stall_led", 32'(dif.led), 32'h4);
    ext_busy = 1'b0;
    wait_idle("restart", 5000);
    check_stream("restart");
    check_val("busy_violations", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
